// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution engine: widths, FSM encoding,
// window/kernel container types, the identity kernel and the output clamp.
package conv_pkg;

    localparam int PIX_W      = 8;
    localparam int COEF_W     = 8;
    localparam int ACC_W      = 21;
    localparam int PROD_W     = PIX_W + 1 + COEF_W;   // unsigned 8 x signed 8
    localparam int N_TAPS     = 9;
    localparam int ROW_TAPS   = 3;
    localparam int PIPE_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Element k holds tap k (pixelr(k+1) / coef[k]); element 4 is the centre.
    typedef logic [N_TAPS-1:0][PIX_W-1:0]  window_t;
    typedef logic [N_TAPS-1:0][COEF_W-1:0] kernel_t;

    // Identity kernel: centre tap = 1, every other tap = 0.
    localparam kernel_t DEFAULT_KERNEL = kernel_t'({32'h0000_0000, 8'h01, 32'h0000_0000});

    // Saturate a signed accumulator value into the unsigned pixel range.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
        logic [PIX_W-1:0] r;
        if (v[ACC_W-1]) begin
            r = 8'd0;
        end else if (|v[ACC_W-2:PIX_W]) begin
            r = 8'd255;
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// Three-stage multiply/accumulate datapath: products, row sums, then
// final sum with rounding, arithmetic shift and clamp. A valid bit rides
// alongside the data so gaps in the input show up as gaps at the output.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  window_t          pix,
    input  kernel_t          coef,
    output logic [PIX_W-1:0] pixel_out,
    output logic             out_valid
);

    // Half an output LSB, zero when no shift is applied.
    localparam logic signed [ACC_W-1:0] RND = ACC_W'((2 ** SHIFT) / 2);

    logic signed [PROD_W-1:0] prod_r [N_TAPS];
    logic signed [ACC_W-1:0]  row_r  [ROW_TAPS];
    logic                     v1_r;
    logic                     v2_r;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  rnd_s;
    logic signed [ACC_W-1:0]  shf_s;

    // S1: register the nine pixel x coefficient products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                prod_r[k] <= {PROD_W{1'b0}};
            end
        end else begin
            v1_r <= in_valid;
            for (int k = 0; k < N_TAPS; k++) begin
                prod_r[k] <= PROD_W'($signed({1'b0, pix[k]})) * PROD_W'($signed(coef[k]));
            end
        end
    end

    // S2: register one partial sum per kernel row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r <= 1'b0;
            for (int r = 0; r < ROW_TAPS; r++) begin
                row_r[r] <= {ACC_W{1'b0}};
            end
        end else begin
            v2_r <= v1_r;
            for (int r = 0; r < ROW_TAPS; r++) begin
                row_r[r] <= ACC_W'(prod_r[3*r]) + ACC_W'(prod_r[3*r+1]) + ACC_W'(prod_r[3*r+2]);
            end
        end
    end

    // Final sum, round-to-nearest offset and arithmetic normalisation shift.
    always_comb begin
        sum_s = row_r[0] + row_r[1] + row_r[2];
        rnd_s = sum_s + RND;
        shf_s = rnd_s >>> SHIFT;
    end

    // S3: clamp into the pixel range; the output stays 0 whenever not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pixel_out <= 8'd0;
        end else begin
            out_valid <= v2_r;
            if (v2_r) begin
                pixel_out <= clamp_pix(shf_s);
            end else begin
                pixel_out <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: frame FSM, accepted-window counter and the
// coefficient register file around the conv3x3_mac datapath.
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     win_valid,
    input  logic [PIX_W-1:0]         pixelr1,
    input  logic [PIX_W-1:0]         pixelr2,
    input  logic [PIX_W-1:0]         pixelr3,
    input  logic [PIX_W-1:0]         pixelr4,
    input  logic [PIX_W-1:0]         pixelr5,
    input  logic [PIX_W-1:0]         pixelr6,
    input  logic [PIX_W-1:0]         pixelr7,
    input  logic [PIX_W-1:0]         pixelr8,
    input  logic [PIX_W-1:0]         pixelr9,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic [PIX_W-1:0]         pixelw,
    output logic                     wr,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(TOTAL + 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       flush_cnt_r;
    kernel_t          coef_r;
    window_t          pix_s;
    logic             accept_s;
    logic             last_s;
    logic             coef_wr_s;
    logic             busy_s;
    logic             frame_done_s;

    assign pix_s     = {pixelr9, pixelr8, pixelr7, pixelr6, pixelr5,
                        pixelr4, pixelr3, pixelr2, pixelr1};
    assign accept_s  = win_valid && (state_r == ST_RUN);
    assign last_s    = (cnt_r == CNT_W'(TOTAL - 1));
    // The kernel is frozen outside IDLE; out-of-range indices are dropped.
    assign coef_wr_s = coef_we && (state_r == ST_IDLE) && (coef_addr < 4'(N_TAPS));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == 2'(PIPE_DEPTH - 1)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded one cycle early so the registered copies line up
    // with the state: frame_done lands on the last FLUSH cycle.
    always_comb begin
        busy_s       = (next_state_s != ST_IDLE);
        frame_done_s = (state_r == ST_FLUSH) && (flush_cnt_r == 2'(PIPE_DEPTH - 2));
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            busy       <= busy_s;
            frame_done <= frame_done_s;
        end
    end

    // FLUSH dwell counter: counts the cycles needed to drain the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= 2'd0;
        end else if (state_r == ST_FLUSH) begin
            flush_cnt_r <= flush_cnt_r + 2'd1;
        end else begin
            flush_cnt_r <= 2'd0;
        end
    end

    // Accepted-window counter, cleared when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Coefficient register file, reset to the identity kernel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_r <= DEFAULT_KERNEL;
        end else if (coef_wr_s) begin
            coef_r[coef_addr] <= coef_data;
        end else begin
            coef_r <= coef_r;
        end
    end

    conv3x3_mac #(
        .SHIFT (SHIFT)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept_s),
        .pix       (pix_s),
        .coef      (coef_r),
        .pixel_out (pixelw),
        .out_valid (wr)
    );

endmodule
